inert_intf: RTL and testbench

INERT_INTF -- requirements
Module: inert_intf

---
 rtl/inert_pkg.sv | 43 ++++
 rtl/inert_intf_if.sv | 12 +
 rtl/inertial_integrator.sv | 48 ++++
 rtl/inert_intf.sv | 175 +++++++++++++++++
 tb/tb_inert_intf.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inert_pkg.sv
// Purpose: shared state encodings, SPI command words and fusion constants for the inertial interface.
// Latency: n/a (constants and a pure combinational command lookup).
// Backpressure: n/a.
package inert_pkg;

    typedef logic [2:0] state_t;

    localparam state_t INIT_WAIT = 3'd0;
    localparam state_t CFG       = 3'd1;
    localparam state_t IDLE      = 3'd2;
    localparam state_t RD        = 3'd3;
    localparam state_t UPD       = 3'd4;

    localparam logic [15:0] CFG_CMD0 = 16'h0D02;
    localparam logic [15:0] CFG_CMD1 = 16'h1053;
    localparam logic [15:0] CFG_CMD2 = 16'h1150;
    localparam logic [15:0] CFG_CMD3 = 16'h1460;

    localparam logic [15:0] RD_GYRO_L = 16'hA200;
    localparam logic [15:0] RD_GYRO_H = 16'hA300;
    localparam logic [15:0] RD_AZ_L   = 16'hAC00;
    localparam logic [15:0] RD_AZ_H   = 16'hAD00;

    localparam logic [15:0] PTCH_RT_OFFSET = 16'h0050;
    localparam int          FUSION_STEP    = 1024;

    function automatic logic [15:0] seq_cmd(input logic rd, input logic [1:0] idx);
        logic [15:0] c;
        c = CFG_CMD0;
        case ({rd, idx})
            3'b000: c = CFG_CMD0;
            3'b001: c = CFG_CMD1;
            3'b010: c = CFG_CMD2;
            3'b011: c = CFG_CMD3;
            3'b100: c = RD_GYRO_L;
            3'b101: c = RD_GYRO_H;
            3'b110: c = RD_AZ_L;
            default: c = RD_AZ_H;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/inert_intf_if.sv
// Purpose: command/response bus between the inertial interface and the external SPI master.
// Latency: n/a (wires only).
// Backpressure: wrt is a one-shot request; the requester holds cmd until done returns.
interface inert_intf_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inertial_integrator.sv
// Purpose: offset-corrects the gyro rate and fuses it with accel-derived pitch in a wrapping 27-bit integrator.
// Latency: ptch/ptch_rt valid one clock after upd.
// Backpressure: none; every upd pulse is consumed.
module inertial_integrator
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd,
    input  logic [15:0] gyro,
    input  logic [15:0] az,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt
);

    logic signed [26:0] ptch_int_q, ptch_int_d;
    logic [15:0]        ptch_rt_q, ptch_rt_d;
    logic [15:0]        rt_new;
    logic signed [15:0] ptch_acc;
    logic signed [26:0] fusion;

    assign ptch    = ptch_int_q[26:11];
    assign ptch_rt = ptch_rt_q;

    always_comb begin
        rt_new     = gyro - PTCH_RT_OFFSET;
        ptch_acc   = $signed({{3{az[15]}}, az[15:3]});
        // Fusion compares against the pitch currently on the output, before this update.
        fusion     = (ptch_acc > $signed(ptch)) ? 27'(FUSION_STEP) : -27'(FUSION_STEP);
        ptch_int_d = ptch_int_q;
        ptch_rt_d  = ptch_rt_q;
        if (upd) begin
            ptch_rt_d  = rt_new;
            ptch_int_d = ptch_int_q - $signed({{11{rt_new[15]}}, rt_new}) + fusion;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int_q <= '0;
            ptch_rt_q  <= '0;
        end else begin
            ptch_int_q <= ptch_int_d;
            ptch_rt_q  <= ptch_rt_d;
        end
    end

endmodule

// File: rtl/inert_intf.sv
// Purpose: powers up and configures the IMU over SPI, then reads gyro/accel on each INT rise and updates pitch.
// Latency: vld one clock after the last read's done; INT-to-first-read is 3-4 clocks through the synchronizer.
// Backpressure: waits on done for every transaction (INERT_TIMEOUT_EN adds a 1023-cycle watchdog back to INIT_WAIT).
module inert_intf
    import inert_pkg::*;
#(
    parameter int fast_sim = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INT,
    inert_intf_if.master      spi,
    output logic              vld,
    output logic [15:0]       ptch,
    output logic [15:0]       ptch_rt
);

    localparam logic [15:0] WAIT_LAST = (fast_sim != 0) ? 16'd511 : 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        vld_q, vld_d;
    logic [7:0]  gyro_l_q, gyro_l_d, gyro_h_q, gyro_h_d;
    logic [7:0]  az_l_q, az_l_d, az_h_q, az_h_d;
    logic        int_ff1_q, int_ff2_q, int_prev_q;
    logic        int_rise;
    logic        upd;
    logic        unused_rd_hi;
`ifdef INERT_TIMEOUT_EN
    logic [9:0]  wd_q, wd_d;
`endif

    assign int_rise     = int_ff2_q & ~int_prev_q;
    assign spi.wrt      = wrt_q;
    assign spi.cmd      = cmd_q;
    assign vld          = vld_q;
    assign unused_rd_hi = ^spi.rd_data[15:8];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        wrt_d    = 1'b0;
        cmd_d    = cmd_q;
        vld_d    = 1'b0;
        gyro_l_d = gyro_l_q;
        gyro_h_d = gyro_h_q;
        az_l_d   = az_l_q;
        az_h_d   = az_h_q;
        upd      = 1'b0;
        case (state_q)
            INIT_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = CFG;
                end
            end
            CFG, RD: begin
                if (!pend_q) begin
                    wrt_d  = 1'b1;
                    cmd_d  = seq_cmd(state_q == RD, idx_q);
                    pend_d = 1'b1;
                end else if (spi.done) begin
                    pend_d = 1'b0;
                    idx_d  = idx_q + 2'd1;
                    if (state_q == RD) begin
                        case (idx_q)
                            2'd0:    gyro_l_d = spi.rd_data[7:0];
                            2'd1:    gyro_h_d = spi.rd_data[7:0];
                            2'd2:    az_l_d   = spi.rd_data[7:0];
                            default: az_h_d   = spi.rd_data[7:0];
                        endcase
                    end
                    if (idx_q == 2'd3) begin
                        state_d = (state_q == CFG) ? IDLE : UPD;
                    end
                end
            end
            IDLE: begin
                if (int_rise) begin
                    idx_d   = '0;
                    state_d = RD;
                end
            end
            UPD: begin
                upd     = 1'b1;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = INIT_WAIT;
        endcase
    end

`ifdef INERT_TIMEOUT_EN
    // A stalled SPI master forces a full re-initialisation; pitch state is kept.
    always_comb begin
        wd_d = '0;
        if (pend_q && !spi.done) begin
            wd_d = wd_q + 10'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_WAIT;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= '0;
            vld_q      <= 1'b0;
            gyro_l_q   <= '0;
            gyro_h_q   <= '0;
            az_l_q     <= '0;
            az_h_q     <= '0;
            int_ff1_q  <= 1'b0;
            int_ff2_q  <= 1'b0;
            int_prev_q <= 1'b0;
`ifdef INERT_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            cmd_q      <= cmd_d;
            vld_q      <= vld_d;
            gyro_l_q   <= gyro_l_d;
            gyro_h_q   <= gyro_h_d;
            az_l_q     <= az_l_d;
            az_h_q     <= az_h_d;
            int_ff1_q  <= INT;
            int_ff2_q  <= int_ff1_q;
            int_prev_q <= int_ff2_q;
            wrt_q      <= wrt_d;
`ifdef INERT_TIMEOUT_EN
            if (wd_q == 10'h3FF) begin
                state_q <= INIT_WAIT;
                cnt_q   <= '0;
                idx_q   <= '0;
                pend_q  <= 1'b0;
                wrt_q   <= 1'b0;
                wd_q    <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                idx_q   <= idx_d;
                pend_q  <= pend_d;
                wd_q    <= wd_d;
            end
`else
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
`endif
        end
    end

    inertial_integrator u_integ (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd     (upd),
        .gyro    ({gyro_h_q, gyro_l_q}),
        .az      ({az_h_q, az_l_q}),
        .ptch    (ptch),
        .ptch_rt (ptch_rt)
    );

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: behavioural SPI responder, directed vector table for the pitch math,
// hand sequences for power-up, INT filtering, mid-transaction reset and a withheld done.
module tb_inert_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        vld;
    logic [15:0] ptch, ptch_rt;

    inert_intf_if spi();

    inert_intf #(.fast_sim(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .spi     (spi),
        .vld     (vld),
        .ptch    (ptch),
        .ptch_rt (ptch_rt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [15:0] cmd_log[$];
    int          overlap = 0;
    int          vld_cnt = 0;
    logic [15:0] cur_gyro = 16'h0000;
    logic [15:0] cur_az = 16'h0000;
    logic        hold_done = 1'b0;
    logic signed [26:0] m_int = '0;

    typedef struct {
        logic [15:0] gyro;
        logic [15:0] az;
        logic [15:0] exp_rt;
        logic [15:0] exp_ptch;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // SPI slave: done three cycles after each wrt; high response byte is junk the DUT must ignore.
    initial begin : responder
        bit          busy;
        int          dly;
        logic [15:0] resp;
        busy = 1'b0;
        dly = 0;
        resp = '0;
        spi.done = 1'b0;
        spi.rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            spi.done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (busy && !hold_done) begin
                    dly--;
                    if (dly == 0) begin
                        spi.done = 1'b1;
                        spi.rd_data = resp;
                        busy = 1'b0;
                    end
                end
                if (spi.wrt === 1'b1) begin
                    if (busy && !hold_done) overlap++;
                    cmd_log.push_back(spi.cmd);
                    busy = 1'b1;
                    dly = 3;
                    case (spi.cmd[15:8])
                        8'hA2:   resp = {8'h5A, cur_gyro[7:0]};
                        8'hA3:   resp = {8'h5A, cur_gyro[15:8]};
                        8'hAC:   resp = {8'h5A, cur_az[7:0]};
                        8'hAD:   resp = {8'h5A, cur_az[15:8]};
                        default: resp = 16'hA5A5;
                    endcase
                end
            end
        end
    end

    initial begin : vld_mon
        forever begin
            @(negedge clk);
            if (vld === 1'b1) vld_cnt++;
        end
    end

    task automatic model_step(input logic [15:0] gyro, input logic [15:0] az,
                              output logic [15:0] exp_rt, output logic [15:0] exp_ptch);
        logic signed [15:0] rt_s, acc_s, p_s;
        rt_s  = gyro - 16'h0050;
        acc_s = $signed(az) >>> 3;
        p_s   = m_int[26:11];
        m_int = m_int - 27'(rt_s) + ((acc_s > p_s) ? 27'sd1024 : -27'sd1024);
        exp_rt   = rt_s;
        exp_ptch = m_int[26:11];
    endtask

    task automatic boot(input string tag);
        int n;
        int base;
        logic [15:0] exp_cfg[4];
        exp_cfg[0] = 16'h0D02; exp_cfg[1] = 16'h1053;
        exp_cfg[2] = 16'h1150; exp_cfg[3] = 16'h1460;
        base = cmd_log.size();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (spi.wrt === 1'b1) break;
            n++;
        end
        chk({tag, " init_wait_len"}, n, 512);
        for (int i = 0; i < 300 && cmd_log.size() < base + 4; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk({tag, " cfg_count"}, cmd_log.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s cfg_cmd%0d", tag, k),
                (cmd_log.size() > base + k) ? cmd_log[base + k] : 16'hxxxx, exp_cfg[k]);
        end
    endtask

    task automatic run_event(input string tag, input logic [15:0] gyro, input logic [15:0] az,
                             input logic [15:0] exp_rt, input logic [15:0] exp_ptch);
        int base;
        base = cmd_log.size();
        cur_gyro = gyro;
        cur_az = az;
        INT = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 3) INT = 1'b0;
            if (vld === 1'b1) break;
        end
        INT = 1'b0;
        chk({tag, " vld"}, vld, 1'b1);
        chk({tag, " ptch_rt"}, ptch_rt, exp_rt);
        chk({tag, " ptch"}, ptch, exp_ptch);
        chk({tag, " rd_count"}, cmd_log.size() - base, 4);
        repeat (8) @(negedge clk);
    endtask

    initial begin : main
        logic [15:0] e_rt, e_p, p_hold;
        int bv, bc;

        // gyro, az, expected ptch_rt, expected ptch -- hand-derived from ptch_int = 0
        vecs[0] = '{16'h0050, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[1] = '{16'h0150, 16'h0000, 16'h0100, 16'hFFFF};
        vecs[2] = '{16'h0150, 16'h0000, 16'h0100, 16'h0000};
        vecs[3] = '{16'h0040, 16'h0000, 16'hFFF0, 16'hFFFF};
        vecs[4] = '{16'h0050, 16'h4000, 16'h0000, 16'h0000};
        vecs[5] = '{16'hF050, 16'h4000, 16'hF000, 16'h0002};
        vecs[6] = '{16'h0000, 16'h8000, 16'hFFB0, 16'h0002};
        vecs[7] = '{16'h2050, 16'h0010, 16'h2000, 16'hFFFD};

        repeat (3) @(negedge clk);
        chk("rst wrt", spi.wrt, 1'b0);
        chk("rst cmd", spi.cmd, 16'h0000);
        chk("rst vld", vld, 1'b0);
        chk("rst ptch", ptch, 16'h0000);
        chk("rst ptch_rt", ptch_rt, 16'h0000);

        boot("boot0");

        bc = cmd_log.size();
        for (int v = 0; v < 8; v++) begin
            run_event($sformatf("vec%0d", v), vecs[v].gyro, vecs[v].az, vecs[v].exp_rt, vecs[v].exp_ptch);
            model_step(vecs[v].gyro, vecs[v].az, e_rt, e_p);
            if (v == 0) begin
                chk("rd_cmd0", cmd_log[bc + 0], 16'hA200);
                chk("rd_cmd1", cmd_log[bc + 1], 16'hA300);
                chk("rd_cmd2", cmd_log[bc + 2], 16'hAC00);
                chk("rd_cmd3", cmd_log[bc + 3], 16'hAD00);
            end
        end

        // Ten identical gyro samples; pitch follows the bench model.
        bv = vld_cnt;
        for (int k = 0; k < 10; k++) begin
            model_step(16'h0150, 16'h0000, e_rt, e_p);
            run_event($sformatf("steady%0d", k), 16'h0150, 16'h0000, e_rt, e_p);
        end
        chk("steady vld_pulses", vld_cnt - bv, 10);

        // INT held high: exactly one read sequence.
        bv = vld_cnt;
        bc = cmd_log.size();
        cur_gyro = 16'h0060;
        cur_az = 16'h0400;
        INT = 1'b1;
        repeat (150) @(negedge clk);
        chk("held vld_pulses", vld_cnt - bv, 1);
        chk("held rd_count", cmd_log.size() - bc, 4);
        model_step(cur_gyro, cur_az, e_rt, e_p);
        chk("held ptch", ptch, e_p);
        INT = 1'b0;
        repeat (10) @(negedge clk);

        // Second INT pulse arriving mid-read is dropped.
        bv = vld_cnt;
        bc = cmd_log.size();
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        for (int i = 0; i < 200 && cmd_log.size() < bc + 2; i++) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        repeat (150) @(negedge clk);
        chk("midrd vld_pulses", vld_cnt - bv, 1);
        chk("midrd rd_count", cmd_log.size() - bc, 4);
        model_step(cur_gyro, cur_az, e_rt, e_p);
        chk("midrd ptch", ptch, e_p);
        chk("midrd ptch_rt", ptch_rt, e_rt);

        // Reset during the third configuration write.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst2 ptch_async", ptch, 16'h0000);
        m_int = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bc = cmd_log.size();
        for (int i = 0; i < 2000 && cmd_log.size() < bc + 3; i++) @(negedge clk);
        #2;
        chk("cfg3 in flight", spi.cmd, 16'h1150);
        rst_n = 1'b0;
        #1;
        chk("rst3 wrt", spi.wrt, 1'b0);
        chk("rst3 cmd", spi.cmd, 16'h0000);
        chk("rst3 vld", vld, 1'b0);
        chk("rst3 ptch_rt", ptch_rt, 16'h0000);
        boot("boot1");
        run_event("post_rst", vecs[0].gyro, vecs[0].az, vecs[0].exp_rt, vecs[0].exp_ptch);

        // Withheld done on the first read.
        bv = vld_cnt;
        bc = cmd_log.size();
        p_hold = ptch;
        hold_done = 1'b1;
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        repeat (1700) @(negedge clk);
`ifdef INERT_TIMEOUT_EN
        chk("wd reinit", (cmd_log.size() >= bc + 2) ? cmd_log[bc + 1] : 16'hxxxx, 16'h0D02);
`else
        chk("nowd wrt_count", cmd_log.size() - bc, 1);
        chk("nowd cmd_held", spi.cmd, 16'hA200);
`endif
        chk("hang vld_pulses", vld_cnt - bv, 0);
        chk("hang ptch_held", ptch, p_hold);
        hold_done = 1'b0;
        repeat (10) @(negedge clk);

        chk("wrt_overlap", overlap, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
